// File: rtl/mem_stage_access_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_stage_access_ctrl_if : valid/ack data-memory bus bundle       |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
interface mem_stage_access_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage_access_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_stage_access_ctrl : M-stage load/store bus sequencer with     |
// | pipeline stall, ack timeout and misalignment error.               |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module mem_stage_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  wire logic              clk,
  input  wire logic              rst_p,
  input  wire logic              MemWriteM,
  input  wire logic              MemtoRegM,
  input  wire logic [ADDR_W-1:0] ALUResultM,
  input  wire logic [DATA_W-1:0] WriteDataM,
  output logic                   StallM,
  output logic      [DATA_W-1:0] ReadDataM,
  output logic                   mem_err,
  mem_stage_access_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic access;
  logic aligned;

  assign access  = MemWriteM | MemtoRegM;
  assign aligned = (ALUResultM[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (rst_p) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    StallM  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (access) begin
          StallM = 1'b1;
          if (aligned) begin
            // MemWriteM alone selects direction, so load+store acts as store
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = MemWriteM;
            addr_d  = ALUResultM;
            wdata_d = WriteDataM;
            cnt_d   = '0;
          end else begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end

      REQ: begin
        StallM = 1'b1;
        if (bus.mem_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!we_q) begin
            rdata_d = bus.mem_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          req_d   = 1'b0;
          rdata_d = '0;
          err_d   = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        // Unconditional IDLE so the held instruction is never issued twice
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign ReadDataM     = rdata_q;
  assign mem_err       = err_q;

endmodule
`default_nettype wire

// File: doc/mem_stage_access_ctrl.md
Name: mem_stage_access_ctrl

Overview:
- Memory-stage responder for the E→M pipeline control register.
- Consumes MemWriteM / MemtoRegM with the M-stage address and store data.
- Runs one load or store per instruction on a multi-cycle valid/ack data-memory bus, drives Stall back to the E→M register (and upstream) until the access completes, and presents ReadDataM toward the M→W register.
- Includes a timeout counter and a misalignment check.

Parameters:
- ADDR_W, 32, memory address width.
- DATA_W, 32, data width.
- TIMEOUT, 15, maximum REQ cycles waiting for mem_ack before the access is aborted (>=1).
- CNT_W, 4, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_p  in  1  reset, synchronous, active-high.
- MemWriteM  in  1  M-stage instruction is a store.
- MemtoRegM  in  1  M-stage instruction is a load.
- ALUResultM  in  ADDR_W  access address.
- WriteDataM  in  DATA_W  store data.
- mem_req  out  1  bus request (registered).
- mem_we  out  1  bus write enable (registered, valid with mem_req).
- mem_addr  out  ADDR_W  bus address (registered).
- mem_wdata  out  DATA_W  bus write data (registered).
- mem_ack  in  1  bus completion; sampled only while mem_req=1.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- StallM  out  1  hold E→M and earlier pipeline registers (combinational from state and inputs).
- ReadDataM  out  DATA_W  load result (registered).
- mem_err  out  1  sticky error flag for timeout or misaligned access.

Behaviour:
- Reset (rst_p=1 at posedge):
  - state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ReadDataM=0, mem_err=0, counter=0.
  - StallM=0 while in IDLE with no access pending.
  - Reset mid-access drops mem_req on the same edge; a late mem_ack afterwards is ignored.
- access = MemWriteM | MemtoRegM. If both are 1, the access is treated as a store (MemWriteM wins).
- States: IDLE, REQ, DONE.
- IDLE:
  - access=0: stay; StallM=0.
  - access=1 and ALUResultM[1:0]==0:
    - StallM=1.
    - Next edge: go to REQ with mem_req=1, mem_we=MemWriteM, mem_addr=ALUResultM, mem_wdata=WriteDataM, counter=0.
  - access=1 and ALUResultM[1:0]!=0 (misaligned):
    - StallM=1.
    - Next edge: go to DONE with mem_err=1 and ReadDataM=0; no bus request is issued.
- REQ:
  - StallM=1. mem_req and the other bus outputs are held stable until ack or timeout.
  - mem_ack=1: next edge go to DONE, mem_req=0. If mem_we=0, ReadDataM=mem_rdata; on a store, ReadDataM is unchanged.
  - mem_ack=0 and counter==TIMEOUT-1: next edge go to DONE, mem_req=0, ReadDataM=0, mem_err=1.
  - Otherwise: counter+1.
- DONE:
  - StallM=0, so the pipeline advances at this edge and ReadDataM is valid this cycle.
  - Next edge always returns to IDLE, even if a new access is already present. This guarantees a fresh instruction is seen in IDLE and an access is never re-issued.
- Latency:
  - Minimum 2 stall cycles per access (IDLE, REQ with immediate ack), then DONE.
  - Stall cycles = 1 + (cycles in REQ).
  - Back-to-back accesses add 1 non-stalled DONE cycle between them.
- mem_err: once set, stays 1 until reset. Later accesses proceed normally.
- mem_ack outside REQ is ignored. Inputs are not re-sampled during REQ; the held E→M register keeps them stable.
- The counter saturates and does not wrap; TIMEOUT=1 means a single REQ cycle.

Test Plan:
- Reset with rst_p=1 for 2 cycles during an active REQ → mem_req=0 on the next edge, state IDLE, ReadDataM=0, mem_err=0; a mem_ack=1 one cycle later causes no change.
- Load with ALUResultM=0x0000_0100 and mem_ack on the 1st REQ cycle with mem_rdata=0xDEAD_BEEF → StallM=1 for 2 cycles, mem_addr=0x100, mem_we=0; in DONE, StallM=0 and ReadDataM=0xDEAD_BEEF.
- Store with ALUResultM=0x200, WriteDataM=0x1234_5678, mem_ack after 3 REQ cycles → mem_we=1 and mem_wdata=0x12345678 held for 3 cycles; StallM=1 for 4 cycles; ReadDataM unchanged.
- No ack with TIMEOUT=15 → mem_req high for exactly 15 cycles, then DONE with ReadDataM=0 and mem_err=1; a subsequent normal load succeeds while mem_err stays 1.
- Misaligned load at ALUResultM=0x102 → mem_req never asserted, StallM=1 for 1 cycle, DONE with mem_err=1.
- Two consecutive loads (0x10 → 0xA, 0x14 → 0xB, immediate acks) → two separate bus requests separated by DONE and IDLE cycles; ReadDataM=0xA in the first DONE and 0xB in the second.
